int_controller: RTL and testbench
=================================

// Module: int_controller
//
// PURPOSE
//   Interrupt source side of the CPU interrupt handshake. Latches up to NSRC peripheral
//   requests and raises IntReq to the control unit. Supplies a 16-bit handler vector.
//   Holds the serviced source in-service until the CPU executes RETI
//   (INTERRUPT opcode, sub-code INT_RETI).
//   Sits between the peripherals and the CPU interrupt state (state_t = interrupt).
//
// PARAMETERS
//   NSRC        4        number of interrupt sources (1..8); index 0 = highest priority
//   VEC_BASE    16'h0004 handler address for source 0
//   VEC_STRIDE  2        address step between consecutive source vectors
//
// PORTS
//   Clock      in   1     system clock, all state on rising edge
//   Reset      in   1     synchronous, active-high reset
//   IrqSrc     in   NSRC  peripheral request lines, synchronous to Clock
//   MaskWe     in   1     write strobe for mask register
//   MaskIn     in   NSRC  new mask value (1 = source masked)
//   IntAck     in   1     1-cycle pulse from CPU on entering interrupt state
//   Reti       in   1     1-cycle pulse from CPU when it executes RETI
//   IntReq     out  1     registered request to CPU
//   IntVec     out  16    handler address, PC loads this via PcInt
//   Pending    out  NSRC  pending register
//   Mask       out  NSRC  mask register
//   InService  out  1     high from the accepted IntAck until Reti
//
// BEHAVIOUR
//   Reset values: state IDLE, Pending=0, Mask=all 1s, IntReq=0, IntVec=VEC_BASE, InService=0.
//   Pending capture
//     - Pending[i] is set on any edge where source i is detected; capture ignores Mask.
//     - Mask only gates request generation.
//   Winner
//     - Lowest index i with Pending[i] & ~Mask[i].
//     - IntVec = VEC_BASE + i*VEC_STRIDE, 16-bit, wraps modulo 2^16.
//   State machine: IDLE -> REQ -> SERVICE -> IDLE
//     IDLE
//       - Any unmasked pending bit -> REQ; IntReq=1 on that edge.
//       - Latency: IrqSrc high at edge k -> Pending at k+1 -> IntReq at k+2.
//     REQ
//       - IntReq held high; IntVec (registered) tracks the current winner every cycle.
//       - If no unmasked pending bit remains (mask write), go to IDLE and drop IntReq
//         on the next edge.
//       - IntAck: freeze the winner index, clear its Pending bit, IntReq=0,
//         InService=1, go to SERVICE. IntVec is held until the next REQ.
//     SERVICE
//       - No new IntReq (no nesting).
//       - Pending continues to capture.
//       - Reti: InService=0, go to IDLE; a new REQ is possible on the following edge.
//   Boundary conditions
//     - IntAck outside REQ and Reti outside SERVICE are ignored.
//     - IntAck and Reti in the same cycle: IntAck applies (REQ), Reti is ignored.
//     - Source set and ack-clear of the same Pending bit on one edge: set wins.
//     - MaskWe in the same cycle as IntAck: the ack uses the winner from the old mask;
//       the new mask takes effect next cycle.
//     - Reset in any state returns all registers to reset values on that edge;
//       an outstanding acknowledged interrupt is discarded.
//
// CONFIGURATION
//   INTC_EDGE_EN
//     - Defined: a source is detected on a rising edge (IrqSrc & ~IrqSrc_q).
//       IrqSrc_q resets to 0, so a source already high out of reset fires once.
//     - Undefined: level-sensitive; Pending[i] is set on every edge IrqSrc[i] is high.
//       The handler must deassert the source before RETI, otherwise it re-requests.
//   Latency is the same in both modes.
//
// TESTING
//   - Reset, then MaskIn=4'b0000, IrqSrc=4'b0100 for 1 cycle
//       -> IntReq=1 two edges later, IntVec=16'h0008.
//   - IrqSrc=4'b0110 simultaneously
//       -> IntVec=16'h0006 (source 1); after IntAck, Pending=4'b0100 (edge mode).
//   - In REQ with source 2 the only winner, MaskIn=4'b0100 with MaskWe
//       -> IntReq drops next edge, state IDLE, Pending[2] still 1.
//   - IntAck, then IrqSrc[0] pulses during SERVICE -> no IntReq;
//       after Reti -> IntReq=1 with IntVec=16'h0004.
//   - Level mode, source held high through Reti -> IntReq reasserts within 2 cycles of Reti.
//   - Reset asserted in SERVICE -> InService=0, Pending=0, Mask=4'b1111, IntReq=0 next edge.

Source files
------------

// File: rtl/int_controller.sv
// Interrupt controller: latches peripheral requests, raises a registered IntReq with a
// priority-encoded handler vector, and tracks one in-service interrupt until RETI.
// Optional macro INTC_EDGE_EN selects rising-edge source detection (default: level).
module int_controller #(
   parameter int          NSRC       = 4,
   parameter logic [15:0] VEC_BASE   = 16'h0004,
   parameter int          VEC_STRIDE = 2
) (
   input  logic            Clock_i,
   input  logic            Reset_i,
   input  logic [NSRC-1:0] IrqSrc_i,
   input  logic            MaskWe_i,
   input  logic [NSRC-1:0] MaskIn_i,
   input  logic            IntAck_i,
   input  logic            Reti_i,
   output logic            IntReq_o,
   output logic [15:0]     IntVec_o,
   output logic [NSRC-1:0] Pending_o,
   output logic [NSRC-1:0] Mask_o,
   output logic            InService_o
);

   localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } intc_state_t;

   intc_state_t     state_q;
   logic            int_req_q;
   logic [15:0]     int_vec_q;
   logic            in_service_q;
   logic [NSRC-1:0] pending_q;
   logic [NSRC-1:0] pending_d;
   logic [NSRC-1:0] mask_q;

   logic [NSRC-1:0] detect;
   logic [NSRC-1:0] req_vec;
   logic [NSRC-1:0] ack_clr;
   logic [IDXW-1:0] win_idx;
   logic            win_any;
   logic            ack_take;

`ifdef INTC_EDGE_EN
   logic [NSRC-1:0] irq_src_q;

   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         irq_src_q <= '0;
      end else begin
         irq_src_q <= IrqSrc_i;
      end
   end

   assign detect = IrqSrc_i & ~irq_src_q;
`else
   assign detect = IrqSrc_i;
`endif

   assign req_vec = pending_q & ~mask_q;

   // Scan from the lowest-priority end so the last hit is the lowest index.
   always_comb begin
      win_idx = '0;
      win_any = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_vec[i]) begin
            win_idx = IDXW'(i);
            win_any = 1'b1;
         end
      end
   end

   // An ack is only honoured while a winner exists; otherwise there is nothing to serve.
   assign ack_take = (state_q == REQ) && IntAck_i && win_any;

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_pend
         assign ack_clr[gi]   = ack_take && (win_idx == IDXW'(gi));
         // A new detection on the ack edge re-sets the bit being cleared.
         assign pending_d[gi] = (pending_q[gi] & ~ack_clr[gi]) | detect[gi];
      end
   endgenerate

   function automatic logic [15:0] vec_of(input logic [IDXW-1:0] idx);
      return VEC_BASE + (16'(idx) * 16'(VEC_STRIDE));
   endfunction

   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         state_q      <= IDLE;
         int_req_q    <= 1'b0;
         int_vec_q    <= VEC_BASE;
         in_service_q <= 1'b0;
         pending_q    <= '0;
         mask_q       <= '1;
      end else begin
         pending_q <= pending_d;
         if (MaskWe_i) begin
            mask_q <= MaskIn_i;
         end
         case (state_q)
            IDLE: begin
               if (win_any) begin
                  state_q   <= REQ;
                  int_req_q <= 1'b1;
                  int_vec_q <= vec_of(win_idx);
               end
            end
            REQ: begin
               if (ack_take) begin
                  state_q      <= SERVICE;
                  int_req_q    <= 1'b0;
                  in_service_q <= 1'b1;
                  int_vec_q    <= vec_of(win_idx);
               end else if (win_any) begin
                  int_vec_q <= vec_of(win_idx);
               end else begin
                  state_q   <= IDLE;
                  int_req_q <= 1'b0;
               end
            end
            SERVICE: begin
               if (Reti_i) begin
                  state_q      <= IDLE;
                  in_service_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               int_req_q    <= 1'b0;
               in_service_q <= 1'b0;
            end
         endcase
      end
   end

   assign IntReq_o    = int_req_q;
   assign IntVec_o    = int_vec_q;
   assign Pending_o   = pending_q;
   assign Mask_o      = mask_q;
   assign InService_o = in_service_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: hand-computed vectors checked with immediate assertions.
module tb_int_controller;

   logic        clk;
   logic        rst;
   logic [3:0]  src;
   logic        mwe;
   logic [3:0]  min;
   logic        ack;
   logic        reti;
   logic        int_req;
   logic [15:0] int_vec;
   logic [3:0]  pending;
   logic [3:0]  mask;
   logic        in_service;

   int checks = 0;
   int errors = 0;

   int_controller #(
      .NSRC       (4),
      .VEC_BASE   (16'h0004),
      .VEC_STRIDE (2)
   ) dut (
      .Clock_i     (clk),
      .Reset_i     (rst),
      .IrqSrc_i    (src),
      .MaskWe_i    (mwe),
      .MaskIn_i    (min),
      .IntAck_i    (ack),
      .Reti_i      (reti),
      .IntReq_o    (int_req),
      .IntVec_o    (int_vec),
      .Pending_o   (pending),
      .Mask_o      (mask),
      .InService_o (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-16s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      logic [3:0] exp_pend;
      logic       exp_req;

      rst = 1'b1; src = '0; mwe = 1'b0; min = '0; ack = 1'b0; reti = 1'b0;
      tick();
      tick();
      chk("rst_req",  16'(int_req),    16'h0);
      chk("rst_pend", 16'(pending),    16'h0);
      chk("rst_mask", 16'(mask),       16'hF);
      chk("rst_vec",  int_vec,         16'h0004);
      chk("rst_insv", 16'(in_service), 16'h0);
      rst = 1'b0;

      // Unmask everything, pulse source 2: Pending after one edge, IntReq after two.
      mwe = 1'b1; min = 4'b0000;
      tick();
      mwe = 1'b0;
      chk("mask_wr", 16'(mask), 16'h0);
      src = 4'b0100;
      tick();
      src = 4'b0000;
      chk("t1_pend", 16'(pending), 16'h4);
      chk("t1_req0", 16'(int_req), 16'h0);
      tick();
      chk("t1_req1", 16'(int_req), 16'h1);
      chk("t1_vec",  int_vec,      16'h0008);

      // Source 1 joins while in REQ; vector follows the new winner a cycle later.
      src = 4'b0110;
      tick();
      src = 4'b0000;
      chk("t2_pend", 16'(pending), 16'h6);
      tick();
      chk("t2_vec",  int_vec,      16'h0006);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t2_ack_req",  16'(int_req),    16'h0);
      chk("t2_ack_insv", 16'(in_service), 16'h1);
      chk("t2_ack_pend", 16'(pending),    16'h4);
      chk("t2_ack_vec",  int_vec,         16'h0006);

      // Reti returns to IDLE; remaining source 2 re-requests on the next edge.
      reti = 1'b1;
      tick();
      reti = 1'b0;
      chk("t2_reti_insv", 16'(in_service), 16'h0);
      chk("t2_reti_req",  16'(int_req),    16'h0);
      tick();
      chk("t2_rereq", 16'(int_req), 16'h1);
      chk("t2_revec", int_vec,      16'h0008);

      // Mask source 2 while it is the only winner: IntReq drops one edge after the mask lands.
      mwe = 1'b1; min = 4'b0100;
      tick();
      mwe = 1'b0;
      chk("t3_mask",  16'(mask),    16'h4);
      chk("t3_req_h", 16'(int_req), 16'h1);
      tick();
      chk("t3_req_l", 16'(int_req), 16'h0);
      chk("t3_pend",  16'(pending), 16'h4);

      // Ack while IDLE is ignored.
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t3_ack_idle_pend", 16'(pending),    16'h4);
      chk("t3_ack_idle_insv", 16'(in_service), 16'h0);

      // Unmask, service source 2, pulse source 0 during SERVICE.
      mwe = 1'b1; min = 4'b0000;
      tick();
      mwe = 1'b0;
      tick();
      chk("t4_req", 16'(int_req), 16'h1);
      chk("t4_vec", int_vec,      16'h0008);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t4_insv", 16'(in_service), 16'h1);
      chk("t4_pend", 16'(pending),    16'h0);
      src = 4'b0001;
      tick();
      src = 4'b0000;
      tick();
      tick();
      chk("t4_nonest_req",  16'(int_req), 16'h0);
      chk("t4_nonest_pend", 16'(pending), 16'h1);
      reti = 1'b1;
      tick();
      reti = 1'b0;
      chk("t4_reti_insv", 16'(in_service), 16'h0);
      tick();
      chk("t4_src0_req", 16'(int_req), 16'h1);
      chk("t4_src0_vec", int_vec,      16'h0004);

      // IntAck and Reti together in REQ: ack applies, Reti is ignored.
      ack = 1'b1; reti = 1'b1;
      tick();
      ack = 1'b0; reti = 1'b0;
      chk("t5_insv", 16'(in_service), 16'h1);
      chk("t5_pend", 16'(pending),    16'h0);
      tick();
      chk("t5_hold_insv", 16'(in_service), 16'h1);
      reti = 1'b1;
      tick();
      reti = 1'b0;

      // Source set and ack-clear of the same bit on one edge: set wins.
      src = 4'b0010;
      tick();
      src = 4'b0000;
      tick();
      chk("t6_vec", int_vec, 16'h0006);
      ack = 1'b1; src = 4'b0010;
      tick();
      ack = 1'b0; src = 4'b0000;
      chk("t6_setwins_pend", 16'(pending),    16'h2);
      chk("t6_setwins_insv", 16'(in_service), 16'h1);

      // Reset while in SERVICE discards everything.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t7_insv", 16'(in_service), 16'h0);
      chk("t7_pend", 16'(pending),    16'h0);
      chk("t7_mask", 16'(mask),       16'hF);
      chk("t7_req",  16'(int_req),    16'h0);
      chk("t7_vec",  int_vec,         16'h0004);

      // Source 3 held high across ack and Reti: level mode re-requests, edge mode does not.
`ifdef INTC_EDGE_EN
      exp_pend = 4'b0000;
      exp_req  = 1'b0;
`else
      exp_pend = 4'b1000;
      exp_req  = 1'b1;
`endif
      mwe = 1'b1; min = 4'b0000;
      tick();
      mwe = 1'b0;
      src = 4'b1000;
      tick();
      tick();
      chk("t8_req", 16'(int_req), 16'h1);
      chk("t8_vec", int_vec,      16'h000A);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t8_ack_pend", 16'(pending), 16'(exp_pend));
      reti = 1'b1;
      tick();
      reti = 1'b0;
      tick();
      chk("t8_rereq", 16'(int_req), 16'(exp_req));
      src = 4'b0000;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
